// File: rtl/pss_arb_pkg.sv
// Shared types for the two-master memory arbiter.
// mid_t carries the master ID, and state_t encodes the grant FSM states.
package pss_arb_pkg;

    typedef logic mid_t;

    localparam mid_t M_CPU = 1'b0;
    localparam mid_t M_UDM = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/pss_arb_idfifo.sv
// In-order FIFO of master IDs for the reads that are still outstanding.
// The head is read combinationally so that a response can be steered in the cycle it arrives.
module pss_arb_idfifo
    import pss_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic arstn_i,
    input  logic push_i,
    input  logic pop_i,
    input  mid_t din_i,
    output mid_t dout_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    mid_t        r_mem [DEPTH];

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push_i) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (pop_i)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // At full, a simultaneous pop reads the old head before the push overwrites that slot.
    always_ff @(posedge clk_i) begin
        if (push_i) r_mem[r_wr_ptr[AW-1:0]] <= din_i;
    end

    assign dout_o  = r_mem[r_rd_ptr[AW-1:0]];
    assign empty_o = (r_wr_ptr == r_rd_ptr);
    assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/pss_mem_arbiter.sv
// Round-robin arbiter that lets the CPU (m0) and UDM (m1) share one memory port.
// It routes in-order read responses back to the issuing master through the ID FIFO.
module pss_mem_arbiter
    import pss_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                clk_i,
    input  logic                arstn_i,
    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    output logic                m0_ack_o,
    output logic                m0_resp_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    output logic                m1_ack_o,
    output logic                m1_resp_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                s_req_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W/8-1:0] s_be_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    input  logic                s_ack_i,
    input  logic                s_resp_i,
    input  logic [DATA_W-1:0]   s_rdata_i,
    output logic                err_o
);

    state_t r_state;
    state_t w_state_next;
    mid_t   r_rr_last;
    mid_t   r_lock_id;
    logic   r_err;

    mid_t   w_gnt;
    mid_t   w_head;
    logic   w_req;
    logic   w_xfer;
    logic   w_sel_we;
    logic   w_push;
    logic   w_pop;
    logic   w_full;
    logic   w_empty;
    logic   w_rd_block;
    logic   w_elig0;
    logic   w_elig1;

    // A pop in the same cycle frees the slot, so a read can still be granted at full.
    assign w_pop      = s_resp_i & ~w_empty;
    assign w_rd_block = w_full & ~w_pop;
    assign w_elig0    = m0_req_i & (m0_we_i | ~w_rd_block);
    assign w_elig1    = m1_req_i & (m1_we_i | ~w_rd_block);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state   <= ST_IDLE;
            r_rr_last <= M_UDM;
            r_lock_id <= M_CPU;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_lock_id <= w_gnt;
            if (w_xfer)              r_rr_last <= w_gnt;
            if (s_resp_i && w_empty) r_err     <= 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_req && !s_ack_i) w_state_next = ST_LOCKED;
            ST_LOCKED: if (w_xfer)            w_state_next = ST_IDLE;
            default:                          w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_gnt = r_lock_id;
        w_req = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req = w_elig0 | w_elig1;
                if (w_elig0 && w_elig1) w_gnt = ~r_rr_last;
                else                    w_gnt = w_elig1 ? M_UDM : M_CPU;
            end
            ST_LOCKED: begin
                w_gnt = r_lock_id;
                w_req = (r_lock_id == M_UDM) ? m1_req_i : m0_req_i;
            end
            default: begin
                w_gnt = M_CPU;
                w_req = 1'b0;
            end
        endcase
    end

    assign w_xfer   = w_req & s_ack_i;
    assign w_sel_we = (w_gnt == M_UDM) ? m1_we_i : m0_we_i;
    assign w_push   = w_xfer & ~w_sel_we;

    pss_arb_idfifo #(
        .DEPTH (MAX_OUTST)
    ) u_idfifo (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .din_i   (w_gnt),
        .dout_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Every output is forced low while reset is asserted, including the combinational paths.
    assign s_req_o   = arstn_i & w_req;
    assign s_we_o    = arstn_i & w_sel_we;
    assign s_addr_o  = !arstn_i ? '0 : ((w_gnt == M_UDM) ? m1_addr_i  : m0_addr_i);
    assign s_be_o    = !arstn_i ? '0 : ((w_gnt == M_UDM) ? m1_be_i    : m0_be_i);
    assign s_wdata_o = !arstn_i ? '0 : ((w_gnt == M_UDM) ? m1_wdata_i : m0_wdata_i);

    assign m0_ack_o   = arstn_i & w_xfer & (w_gnt == M_CPU);
    assign m1_ack_o   = arstn_i & w_xfer & (w_gnt == M_UDM);
    assign m0_resp_o  = arstn_i & w_pop & (w_head == M_CPU);
    assign m1_resp_o  = arstn_i & w_pop & (w_head == M_UDM);
    assign m0_rdata_o = m0_resp_o ? s_rdata_i : '0;
    assign m1_rdata_o = m1_resp_o ? s_rdata_i : '0;
    assign err_o      = r_err;

endmodule
